// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: valid/ready front end that drives the analog-level SRAM bus,
// generates the strobe, waits SETTLE_CYCLES and slices dout_a back into bits.
module sram_access_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int ANA_WIDTH     = 8,
    parameter int FULL_SCALE    = 255,
    parameter int TH_LO         = 85,
    parameter int TH_HI         = 170,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ANA_WIDTH-1:0]  clk_a,
    output logic [ANA_WIDTH-1:0]  we_a,
    output logic [ANA_WIDTH-1:0]  addr_a [ADDR_WIDTH],
    output logic [ANA_WIDTH-1:0]  din_a [DATA_WIDTH],
    input  logic [ANA_WIDTH-1:0]  dout_a [DATA_WIDTH]
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SETTLE, HOLD, RESP} state_t;
    localparam logic [ANA_WIDTH-1:0] HI   = ANA_WIDTH'(FULL_SCALE);
    localparam logic [ANA_WIDTH-1:0] LO_T = ANA_WIDTH'(TH_LO);
    localparam logic [ANA_WIDTH-1:0] HI_T = ANA_WIDTH'(TH_HI);
    localparam logic [ANA_WIDTH-1:0] MID  = ANA_WIDTH'(FULL_SCALE / 2);
    state_t state;
    logic we;
    logic [3:0] cnt;
    logic [DATA_WIDTH-1:0] bits;
    logic marg;
    assign req_ready = rst_n && state == IDLE;
    // Marginal band lanes still resolve to a bit by mid-scale, but raise the error flag.
    always_comb begin
        bits = '0;
        marg = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            bits[i] = dout_a[i] > HI_T || (dout_a[i] >= LO_T && dout_a[i] > MID);
            marg    = marg || (dout_a[i] >= LO_T && dout_a[i] <= HI_T);
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            we        <= 1'b0;
            cnt       <= '0;
            clk_a     <= '0;
            we_a      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < ADDR_WIDTH; i++) addr_a[i] <= '0;
            for (int i = 0; i < DATA_WIDTH; i++) din_a[i] <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    we    <= req_we;
                    we_a  <= req_we ? HI : '0;
                    for (int i = 0; i < ADDR_WIDTH; i++) addr_a[i] <= req_addr[i] ? HI : '0;
                    for (int i = 0; i < DATA_WIDTH; i++) din_a[i] <= req_wdata[i] ? HI : '0;
                    state <= SETUP;
                end
                SETUP: begin
                    clk_a <= HI;
                    state <= STROBE;
                end
                STROBE: begin
                    clk_a <= '0;
                    cnt   <= 4'(SETTLE_CYCLES - 1);
                    state <= we ? HOLD : SETTLE;
                end
                SETTLE: if (cnt == '0) begin
                    rsp_rdata <= bits;
                    rsp_err   <= marg;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                HOLD: begin
                    we_a      <= '0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
